instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  - IF stage directly upstream of controlunit. Owns the PC and fetches 32-bit words from
//    instruction memory over a req/gnt + rvalid interface.
//  - Buffers returned words in an in-order FIFO.
//  - Presents the head instruction to decode as opcode=instr[31:26], funct=instr[5:0],
//    with a valid/ready handshake.
//  - Supports PC redirect (branch/jump) with flush of buffered and in-flight fetches.
// PARAMETERS
//  ADDR_W    32  PC / imem address width
//  DEPTH     4   FIFO entries; power of 2, >=2; also max (buffered + outstanding) fetches
//  RESET_PC  0   PC value loaded on reset; must be word aligned
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous reset, active low
//  imem_req     out  1       fetch request
//  imem_addr    out  ADDR_W  fetch address (= PC)
//  imem_gnt     in   1       request accepted this cycle
//  imem_rvalid  in   1       read data valid; responses return in request order
//  imem_rdata   in   32      instruction word
//  redirect     in   1       load redirect_pc, flush
//  redirect_pc  in   ADDR_W  new PC
//  id_ready     in   1       decode accepts head instruction
//  id_valid     out  1       head instruction valid
//  id_instr     out  32      head instruction word
//  id_pc        out  ADDR_W  PC of head instruction
//  opcode       out  6       id_instr[31:26] to controlunit
//  funct        out  6       id_instr[5:0] to controlunit
// BEHAVIOUR
//  - Reset (async, rst_n=0): pc=RESET_PC, FIFO empty, outstanding=0, drop=0; imem_req=0,
//    id_valid=0, id_instr/opcode/funct=0, id_pc=RESET_PC.
//  - Request: imem_req = (count+outstanding < DEPTH) && !redirect. imem_addr=pc, held stable
//    until imem_gnt. On req&&gnt: pc<=pc+4 (wraps mod 2^ADDR_W), outstanding+1.
//  - Response: imem_rvalid decrements outstanding. If drop>0: discard, drop-1. Else push
//    {rdata, fetch pc} into FIFO. Push into a full FIFO cannot occur by credit rule;
//    the bench checks this.
//  - Decode side: id_valid = FIFO non-empty; id_* = head entry, combinational from FIFO.
//    Pop on id_valid&&id_ready. When empty: id_instr=0 (NOP), opcode=0, funct=0.
//  - Simultaneous push and pop: count unchanged; pop on full FIFO frees a credit next cycle.
//  - Redirect (sampled at clk edge): FIFO cleared, pc<=redirect_pc with [1:0] forced to 00.
//    drop <= outstanding after the same-cycle rvalid is counted; a grant in that cycle is
//    impossible since imem_req=0. Redirect wins over a same-cycle pop or push; the
//    pushed/popped word is discarded.
//  - Back-to-back redirects: last one wins; drop accumulates correctly.
//  - id_valid falls the cycle after redirect and rises no earlier than 2 cycles after
//    redirect (1 req cycle + >=1 memory latency).
//  - Latency: gnt at cycle N, rvalid at N+k (k>=1), id_valid no later than N+k+1 if FIFO
//    otherwise empty (push registered; head visible the cycle after push).
// CONFIGURATION
//  - IFU_PERF_CNT_EN defined: adds outputs perf_fetched[31:0] and perf_bubble[31:0].
//    - perf_fetched: +1 per pop.
//    - perf_bubble: +1 per cycle with id_ready=1 && id_valid=0.
//    - Both reset to 0, saturate at 32'hFFFF_FFFF, not cleared by redirect.
//  - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. Reset with RESET_PC=32'h100, mem gnt=1, latency 1, id_ready=1 -> imem_addr 100,104,108...;
//     id_pc follows 2 cycles behind; opcode/funct match imem_rdata fields.
//  2. Word 32'h0022_0020 (add) -> opcode=6'b000000, funct=6'b100000 presented with id_valid=1.
//  3. id_ready=0 for 10 cycles, gnt=1 -> exactly DEPTH=4 grants, then imem_req=0; FIFO holds
//     addrs 0,4,8,C in order, no loss.
//  4. Redirect to 32'h203 with 2 outstanding -> next imem_addr=32'h200; both stale responses
//     dropped; first id_pc=32'h200.
//  5. Redirect same cycle as pop and rvalid -> FIFO empty next cycle, no stale word ever seen
//     at id_valid.
//  6. rst_n low mid-fetch with outstanding=3 -> all outputs at reset values immediately
//     (async); restart fetch from RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word fetches over req/gnt,
// collects in-order rvalid responses in a small FIFO, and presents the head
// word (plus opcode/funct fields) to decode with a valid/ready handshake.
// A redirect loads a new PC, clears the FIFO and drops in-flight responses.
// Optional build macro IFU_PERF_CNT_EN adds saturating pop/bubble counters.
module instr_fetch_unit #(
  parameter int               ADDR_W   = 32,
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              id_ready,
  output logic              id_valid,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [5:0]        opcode,
  output logic [5:0]        funct
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubble
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;   // fetch PC of the next non-dropped response
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  outst_q, outst_d;       // includes responses that will be dropped
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic [31:0]       instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

  logic              fire;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    inflight;
  logic [ADDR_W-1:0] redirect_pc_aligned;

  // Credits cover both buffered words and fetches still in flight, so a
  // response always finds a free FIFO slot.
  assign inflight            = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req            = rst_n && (inflight < (CNT_W+1)'(DEPTH)) && !redirect;
  assign imem_addr           = pc_q;
  assign fire                = imem_req && imem_gnt;
  assign push                = imem_rvalid && (drop_q == '0) && !redirect;
  assign pop                 = id_valid && id_ready && !redirect;
  assign redirect_pc_aligned = redirect_pc & ~ADDR_W'(3);

  assign id_valid = (count_q != '0);
  assign id_instr = id_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign id_pc    = id_valid ? pc_mem_q[rd_ptr_q] : resp_pc_q;
  assign opcode   = id_instr[31:26];
  assign funct    = id_instr[5:0];

  // Next-state for PC, FIFO control and outstanding/drop bookkeeping.
  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    outst_d   = outst_q + CNT_W'(fire) - CNT_W'(imem_rvalid);
    drop_d    = drop_q;
    if (redirect) begin
      // Every fetch still pending after this cycle's response is stale.
      pc_d      = redirect_pc_aligned;
      resp_pc_d = redirect_pc_aligned;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      drop_d    = outst_q - CNT_W'(imem_rvalid);
    end else begin
      if (fire)
        pc_d = pc_q + ADDR_W'(4);
      if (imem_rvalid && (drop_q != '0))
        drop_d = drop_q - CNT_W'(1);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        resp_pc_d = resp_pc_q + ADDR_W'(4);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
    end
  end

  // FIFO storage; contents are only observed through count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

`ifdef IFU_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] fetched_q;
  logic [31:0] bubble_q;

  assign perf_fetched = fetched_q;
  assign perf_bubble  = bubble_q;

  // Saturating counters of delivered instructions and starved decode cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      bubble_q  <= '0;
    end else begin
      if (pop)
        fetched_q <= sat_inc(fetched_q);
      if (id_ready && !id_valid)
        bubble_q <= sat_inc(bubble_q);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a behavioural memory with random
// grant and in-order random-latency responses, and a queue-based reference
// model of PC sequencing, FIFO contents and redirect/drop behaviour.
module tb_instr_fetch_unit;

  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [5:0]  opcode;
  logic [5:0]  funct;

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .opcode(opcode), .funct(funct)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  typedef struct { logic [31:0] addr; bit stale; } fetch_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { logic [31:0] data; int due; } resp_t;

  fetch_t      infl[$];   // model: fetches granted but not yet answered
  ent_t        fq[$];     // model: buffered instructions
  resp_t       mq[$];     // memory: pending responses
  logic [31:0] m_pc;
  int          cyc = 0;
  int          last_due = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == RST_PC) return 32'h0022_0020;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic model_reset();
    infl.delete();
    fq.delete();
    mq.delete();
    m_pc     = RST_PC;
    last_due = 0;
  endtask

  // One clock cycle: starts and ends at a falling edge.
  task automatic cycle(input bit rdy, input bit gnt, input bit redir,
                       input logic [31:0] rpc, input int lat);
    bit          exp_req, gr, rv;
    logic [31:0] gaddr;
    fetch_t      f;
    int          d;
    id_ready    = rdy;
    imem_gnt    = gnt;
    redirect    = redir;
    redirect_pc = rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mq[0].data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    exp_req = ((fq.size() + infl.size()) < DEPTH) && !redir;
    check_eq("imem_req", imem_req, exp_req);
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("id_valid", id_valid, fq.size() != 0);
    if (fq.size() != 0) begin
      check_eq("id_instr", id_instr, fq[0].instr);
      check_eq("id_pc", id_pc, fq[0].pc);
      check_eq("opcode", opcode, fq[0].instr[31:26]);
      check_eq("funct", funct, fq[0].instr[5:0]);
    end else begin
      check_eq("nop_instr", id_instr, 32'h0);
      check_eq("nop_opcode", opcode, 6'h0);
      check_eq("nop_funct", funct, 6'h0);
    end
    gr    = imem_req && gnt;
    gaddr = imem_addr;
    rv    = imem_rvalid;
    @(posedge clk);
    // memory environment reacts to what the DUT actually requested
    if (rv) void'(mq.pop_front());
    if (gr) begin
      d = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq.push_back('{data: mem_word(gaddr), due: d});
      last_due = d;
    end
    // reference model
    if (rv && infl.size() == 0) begin
      check_eq("orphan_resp", 32'd1, 32'd0);
      rv = 1'b0;
    end
    if (redir) begin
      fq.delete();
      if (rv) void'(infl.pop_front());
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_pc = rpc & ~32'd3;
    end else begin
      if (rdy && fq.size() != 0) void'(fq.pop_front());
      if (rv) begin
        f = infl.pop_front();
        if (!f.stale) begin
          check_eq("fifo_room", fq.size() < DEPTH, 1'b1);
          fq.push_back('{instr: mem_word(f.addr), pc: f.addr});
        end
      end
      if (exp_req && gnt) begin
        infl.push_back('{addr: m_pc, stale: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react without a clock edge.
  task automatic do_reset();
    #2;
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    id_ready    = 1'b0;
    #1;
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_valid", id_valid, 1'b0);
    check_eq("rst_instr", id_instr, 32'h0);
    check_eq("rst_opcode", opcode, 6'h0);
    check_eq("rst_funct", funct, 6'h0);
    check_eq("rst_id_pc", id_pc, RST_PC);
    check_eq("rst_addr", imem_addr, RST_PC);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    return 32'($urandom_range(0, 4095));
  endfunction

  initial begin
    rst_n       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    id_ready    = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // streaming fetch from reset PC, full grant, latency 1
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, '0, 1);

    // decode stalled: fetch must stop after DEPTH credits, then drain in order
    cycle(1'b0, 1'b1, 1'b1, 32'h0, 1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, '0, 1);
    for (int i = 0; i < 8; i++)  cycle(1'b1, 1'b1, 1'b0, '0, 1);

    // redirect to an unaligned target with fetches still in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, '0, 3);
    cycle(1'b1, 1'b1, 1'b1, 32'h203, 3);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, '0, 3);

    // back-to-back redirects
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, '0, 2);
    cycle(1'b1, 1'b1, 1'b1, 32'h400, 2);
    cycle(1'b1, 1'b1, 1'b1, 32'h800, 2);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 1'b0, '0, 2);

    // async reset with fetches outstanding, then restart
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0, 4);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, '0, 1);

    // randomized traffic with occasional mid-run resets
    for (int i = 0; i < 2000; i++) begin
      if (i % 700 == 699) do_reset();
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8,
            $urandom_range(0, 19) == 0, rand_pc(), $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
